// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core datapath.
//   XLEN       : datapath width
//   reg_idx_t  : architectural register index (x0..x31)
//   load_f3_e  : funct3 encodings of the legal integer loads
package npc_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

endpackage

// File: rtl/wb_unit_load_ext.sv
// load_ext: combinational extraction and sign/zero extension of load data.
// Ports:
//   rdata   in  raw aligned memory word
//   offset  in  byte address bits [1:0]
//   funct3  in  load type
//   data    out extracted, extended value (0 for an illegal funct3)
//   illegal out funct3 is not a legal load encoding
module load_ext
  import npc_pkg::*;
#(
  parameter int DATA_W = npc_pkg::XLEN
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data,
  output logic              illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A halfword load only looks at offset[1]; a misaligned offset[0] is ignored.
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = rdata[{offset[1], 4'b0000} +: 16];
    data     = '0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:   data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_LW:   data = rdata;
      F3_LBU:  data = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(DATA_W-16){1'b0}}, half_sel};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback stage driving the register-file write port.
// Load responses win over ALU results; the winner is registered into a
// single output stage. A per-register scoreboard tracks issued loads whose
// data has not yet been presented to the register file.
// Ports:
//   alu_valid/alu_ready/alu_rd/alu_data       ALU result channel
//   ld_valid/ld_ready/ld_rd/ld_rdata/
//   ld_offset/ld_funct3                       load response channel
//   ld_err                                    illegal-funct3 pulse, aligned with the write
//   iss_valid/iss_rd                          load issue (sets pending bit)
//   q_rs1/q_rs2 -> q_busy1/q_busy2            decode load-use hazard query
//   RegWEn/waddr/wdata                        register-file write port
module wb_unit
  import npc_pkg::*;
#(
  parameter int XLEN = npc_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  reg_idx_t        alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  reg_idx_t        ld_rd,
  input  logic [XLEN-1:0] ld_rdata,
  input  logic [1:0]      ld_offset,
  input  logic [2:0]      ld_funct3,
  output logic            ld_err,
  input  logic            iss_valid,
  input  reg_idx_t        iss_rd,
  input  reg_idx_t        q_rs1,
  input  reg_idx_t        q_rs2,
  output logic            q_busy1,
  output logic            q_busy2,
  output logic            RegWEn,
  output reg_idx_t        waddr,
  output logic [XLEN-1:0] wdata
);

  logic            ld_xfer;
  logic            alu_xfer;
  logic [XLEN-1:0] ext_data;
  logic            ext_illegal;

  logic            regwen_d, regwen_q;
  reg_idx_t        waddr_d, waddr_q;
  logic [XLEN-1:0] wdata_d, wdata_q;
  logic            from_load_d, from_load_q;
  logic            ld_err_d, ld_err_q;
  logic [NREG-1:0] pend_d, pend_q;

  assign ld_ready  = 1'b1;
  assign alu_ready = !ld_valid;
  assign ld_xfer   = ld_valid && ld_ready;
  assign alu_xfer  = alu_valid && alu_ready;

  load_ext #(
    .DATA_W (XLEN)
  ) u_load_ext (
    .rdata   (ld_rdata),
    .offset  (ld_offset),
    .funct3  (ld_funct3),
    .data    (ext_data),
    .illegal (ext_illegal)
  );

  // Output stage: a transfer to x0 is still accepted but never raises RegWEn.
  always_comb begin
    regwen_d    = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    from_load_d = from_load_q;
    ld_err_d    = 1'b0;
    if (ld_xfer) begin
      regwen_d    = (ld_rd != '0);
      waddr_d     = ld_rd;
      wdata_d     = ext_data;
      from_load_d = 1'b1;
      ld_err_d    = ext_illegal;
    end else if (alu_xfer) begin
      regwen_d    = (alu_rd != '0);
      waddr_d     = alu_rd;
      wdata_d     = alu_data;
      from_load_d = 1'b0;
    end
  end

  // Scoreboard: the clear is applied first so a same-cycle issue to the
  // committing register keeps it pending.
  always_comb begin
    pend_d = pend_q;
    if (regwen_q && from_load_q) begin
      pend_d[waddr_q] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      pend_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwen_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      from_load_q <= 1'b0;
      ld_err_q    <= 1'b0;
      pend_q      <= '0;
    end else begin
      regwen_q    <= regwen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      from_load_q <= from_load_d;
      ld_err_q    <= ld_err_d;
      pend_q      <= pend_d;
    end
  end

  // The in-flight term covers the cycle where the write is presented but
  // the register file has not captured it yet.
  assign q_busy1 = pend_q[q_rs1] || (regwen_q && (waddr_q == q_rs1) && (q_rs1 != '0));
  assign q_busy2 = pend_q[q_rs2] || (regwen_q && (waddr_q == q_rs2) && (q_rs2 != '0));

  assign RegWEn = regwen_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign ld_err = ld_err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed extension table, hand-written
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_rdata;
  logic [1:0]  ld_offset;
  logic [2:0]  ld_funct3;
  logic        ld_err;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  q_rs1, q_rs2;
  logic        q_busy1, q_busy2;
  logic        RegWEn;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } ext_vec_t;

  ext_vec_t ext_table[15];

  wb_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_rdata  (ld_rdata),
    .ld_offset (ld_offset),
    .ld_funct3 (ld_funct3),
    .ld_err    (ld_err),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_busy1   (q_busy1),
    .q_busy2   (q_busy2),
    .RegWEn    (RegWEn),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    iss_valid = 1'b0;
  endtask

  task automatic driveLoad(input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [1:0] off, input logic [2:0] f3);
    ld_valid  = 1'b1;
    ld_rd     = rd;
    ld_rdata  = rdata;
    ld_offset = off;
    ld_funct3 = f3;
  endtask

  task automatic driveAlu(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
  endtask

  task automatic applyStimulus(input ext_vec_t v);
    driveLoad(5'd10, v.rdata, v.off, v.f3);
    tick();
    ld_valid = 1'b0;
  endtask

  // Reference load extension written directly from the load-type rules.
  function automatic logic [31:0] refExtend(input logic [31:0] word, input int off,
                                            input int f3, output bit err);
    longint v;
    err = 1'b0;
    case (f3)
      0, 4: begin
        v = longint'((word >> (8 * off)) & 32'hFF);
        if (f3 == 0 && v >= 128) v = v - 256;
      end
      1, 5: begin
        v = longint'((word >> (16 * (off / 2))) & 32'hFFFF);
        if (f3 == 1 && v >= 32768) v = v - 65536;
      end
      2: v = longint'(word);
      default: begin
        v   = 0;
        err = 1'b1;
      end
    endcase
    return 32'(v);
  endfunction

  bit          m_pend[32];
  bit          m_wen, m_from, m_err;
  int          m_addr;
  logic [31:0] m_data;

  initial begin
    bit          n_pend[32];
    bit          n_wen, n_from, n_err, hold_alu;
    int          n_addr;
    logic [31:0] n_data;
    bit          exp_b1, exp_b2;

    ext_table[0]  = '{3'b000, 2'd0, 32'h80FF7F01, 32'h00000001, 1'b0};
    ext_table[1]  = '{3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80, 1'b0};
    ext_table[2]  = '{3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF, 1'b0};
    ext_table[3]  = '{3'b100, 2'd1, 32'h80FF7F01, 32'h0000007F, 1'b0};
    ext_table[4]  = '{3'b100, 2'd2, 32'h80FF7F01, 32'h000000FF, 1'b0};
    ext_table[5]  = '{3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF, 1'b0};
    ext_table[6]  = '{3'b001, 2'd0, 32'h80FF7F01, 32'h00007F01, 1'b0};
    ext_table[7]  = '{3'b001, 2'd3, 32'h80FF7F01, 32'hFFFF80FF, 1'b0};
    ext_table[8]  = '{3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01, 1'b0};
    ext_table[9]  = '{3'b101, 2'd2, 32'h80FF7F01, 32'h000080FF, 1'b0};
    ext_table[10] = '{3'b010, 2'd1, 32'h80FF7F01, 32'h80FF7F01, 1'b0};
    ext_table[11] = '{3'b011, 2'd0, 32'h80FF7F01, 32'h00000000, 1'b1};
    ext_table[12] = '{3'b110, 2'd1, 32'h80FF7F01, 32'h00000000, 1'b1};
    ext_table[13] = '{3'b111, 2'd2, 32'h80FF7F01, 32'h00000000, 1'b1};
    ext_table[14] = '{3'b100, 2'd3, 32'h80FF7F01, 32'h00000080, 1'b0};

    // Reset state
    rst_n = 1'b0;
    idleInputs();
    alu_rd = 5'd0; alu_data = '0;
    ld_rd = 5'd0; ld_rdata = '0; ld_offset = '0; ld_funct3 = '0;
    iss_rd = 5'd0;
    q_rs1 = 5'd3;
    q_rs2 = 5'd7;
    #12;
    checkOutput("reset_RegWEn", 32'(RegWEn), 32'd0);
    checkOutput("reset_waddr", 32'(waddr), 32'd0);
    checkOutput("reset_wdata", wdata, 32'd0);
    checkOutput("reset_ld_err", 32'(ld_err), 32'd0);
    checkOutput("reset_q_busy1", 32'(q_busy1), 32'd0);
    checkOutput("reset_q_busy2", 32'(q_busy2), 32'd0);
    checkOutput("reset_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU only
    driveAlu(5'd5, 32'hDEADBEEF);
    #1;
    checkOutput("alu_only_ready", 32'(alu_ready), 32'd1);
    checkOutput("alu_only_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    checkOutput("alu_only_RegWEn", 32'(RegWEn), 32'd1);
    checkOutput("alu_only_waddr", 32'(waddr), 32'd5);
    checkOutput("alu_only_wdata", wdata, 32'hDEADBEEF);
    tick();
    checkOutput("alu_only_RegWEn_drop", 32'(RegWEn), 32'd0);

    // Extension table
    for (int i = 0; i < 15; i++) begin
      applyStimulus(ext_table[i]);
      checkOutput($sformatf("ext[%0d]_RegWEn", i), 32'(RegWEn), 32'd1);
      checkOutput($sformatf("ext[%0d]_wdata", i), wdata, ext_table[i].exp_data);
      checkOutput($sformatf("ext[%0d]_ld_err", i), 32'(ld_err), 32'(ext_table[i].exp_err));
    end
    tick();
    checkOutput("ext_idle_RegWEn", 32'(RegWEn), 32'd0);
    checkOutput("ext_idle_ld_err", 32'(ld_err), 32'd0);

    // Collision: load first, held ALU result next
    driveAlu(5'd3, 32'h33333333);
    driveLoad(5'd4, 32'h44444444, 2'd0, 3'b010);
    #1;
    checkOutput("coll_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    checkOutput("coll_alu_ready_after", 32'(alu_ready), 32'd1);
    checkOutput("coll_first_waddr", 32'(waddr), 32'd4);
    checkOutput("coll_first_wdata", wdata, 32'h44444444);
    checkOutput("coll_first_RegWEn", 32'(RegWEn), 32'd1);
    tick();
    alu_valid = 1'b0;
    checkOutput("coll_second_RegWEn", 32'(RegWEn), 32'd1);
    checkOutput("coll_second_waddr", 32'(waddr), 32'd3);
    checkOutput("coll_second_wdata", wdata, 32'h33333333);
    tick();
    checkOutput("coll_idle_RegWEn", 32'(RegWEn), 32'd0);

    // Scoreboard sequence on rd 7
    q_rs1 = 5'd7;
    q_rs2 = 5'd6;
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    checkOutput("sb_not_yet_busy", 32'(q_busy1), 32'd0);
    tick();
    iss_valid = 1'b0;
    checkOutput("sb_issued_busy1", 32'(q_busy1), 32'd1);
    checkOutput("sb_other_busy2", 32'(q_busy2), 32'd0);
    driveLoad(5'd7, 32'h00000077, 2'd0, 3'b010);
    tick();
    ld_valid = 1'b0;
    checkOutput("sb_commit_RegWEn", 32'(RegWEn), 32'd1);
    checkOutput("sb_commit_busy1", 32'(q_busy1), 32'd1);
    tick();
    checkOutput("sb_cleared_busy1", 32'(q_busy1), 32'd0);
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    driveLoad(5'd7, 32'h00000078, 2'd0, 3'b010);
    tick();
    ld_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    checkOutput("sb_set_wins_RegWEn", 32'(RegWEn), 32'd0);
    checkOutput("sb_set_wins_busy1", 32'(q_busy1), 32'd1);
    driveLoad(5'd7, 32'h00000079, 2'd0, 3'b010);
    tick();
    ld_valid = 1'b0;
    tick();
    checkOutput("sb_final_clear_busy1", 32'(q_busy1), 32'd0);

    // x0 handling
    driveLoad(5'd0, 32'hFFFFFFFF, 2'd0, 3'b011);
    tick();
    ld_valid = 1'b0;
    checkOutput("x0_ld_err", 32'(ld_err), 32'd1);
    checkOutput("x0_RegWEn", 32'(RegWEn), 32'd0);
    tick();
    checkOutput("x0_ld_err_drop", 32'(ld_err), 32'd0);
    q_rs1 = 5'd0;
    q_rs2 = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd0;
    driveAlu(5'd0, 32'h12345678);
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b0;
    checkOutput("x0_alu_RegWEn", 32'(RegWEn), 32'd0);
    checkOutput("x0_busy1", 32'(q_busy1), 32'd0);
    checkOutput("x0_busy2", 32'(q_busy2), 32'd0);
    tick();

    // Asynchronous reset mid-cycle
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    driveAlu(5'd12, 32'hCAFEF00D);
    tick();
    alu_valid = 1'b0;
    q_rs1 = 5'd9;
    q_rs2 = 5'd12;
    #1;
    checkOutput("arst_pre_RegWEn", 32'(RegWEn), 32'd1);
    checkOutput("arst_pre_busy1", 32'(q_busy1), 32'd1);
    checkOutput("arst_pre_busy2", 32'(q_busy2), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_RegWEn", 32'(RegWEn), 32'd0);
    checkOutput("arst_busy1", 32'(q_busy1), 32'd0);
    checkOutput("arst_busy2", 32'(q_busy2), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("arst_post_RegWEn", 32'(RegWEn), 32'd0);

    // Randomized traffic against the behavioural model
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wen = 1'b0; m_from = 1'b0; m_err = 1'b0; m_addr = 0; m_data = '0;
    hold_alu = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold_alu) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      ld_valid  = ($urandom_range(0, 2) == 0);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_rdata  = $urandom;
      ld_offset = 2'($urandom);
      ld_funct3 = 3'($urandom);
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = 5'($urandom_range(0, 7));
      q_rs1     = 5'($urandom_range(0, 7));
      q_rs2     = 5'($urandom_range(0, 7));
      #1;
      exp_b1 = m_pend[q_rs1] || (m_wen && m_addr == int'(q_rs1) && q_rs1 != 0);
      exp_b2 = m_pend[q_rs2] || (m_wen && m_addr == int'(q_rs2) && q_rs2 != 0);
      checkOutput("rnd_q_busy1", 32'(q_busy1), 32'(exp_b1));
      checkOutput("rnd_q_busy2", 32'(q_busy2), 32'(exp_b2));
      checkOutput("rnd_alu_ready", 32'(alu_ready), 32'(!ld_valid));

      n_pend = m_pend;
      if (m_wen && m_from) n_pend[m_addr] = 1'b0;
      if (iss_valid && iss_rd != 0) n_pend[iss_rd] = 1'b1;
      n_err = 1'b0;
      if (ld_valid) begin
        n_wen  = (ld_rd != 0);
        n_addr = int'(ld_rd);
        n_data = refExtend(ld_rdata, int'(ld_offset), int'(ld_funct3), n_err);
        n_from = 1'b1;
      end else if (alu_valid) begin
        n_wen  = (alu_rd != 0);
        n_addr = int'(alu_rd);
        n_data = alu_data;
        n_from = 1'b0;
      end else begin
        n_wen  = 1'b0;
        n_addr = m_addr;
        n_data = m_data;
        n_from = m_from;
      end
      hold_alu = alu_valid && ld_valid;

      tick();
      m_pend = n_pend; m_wen = n_wen; m_addr = n_addr;
      m_data = n_data; m_from = n_from; m_err = n_err;
      checkOutput("rnd_RegWEn", 32'(RegWEn), 32'(m_wen));
      checkOutput("rnd_ld_err", 32'(ld_err), 32'(m_err));
      if (m_wen) begin
        checkOutput("rnd_waddr", 32'(waddr), 32'(m_addr));
        checkOutput("rnd_wdata", wdata, m_data);
      end
    end
    idleInputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
